// File: rtl/qupls_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : qupls_io_sequencer
// Purpose : Program-ordered queue for uncached I/O loads/stores; issues one op
//           at a time to the uncached port once it is the oldest in the ROB.
// Revision: 1.0 - initial release
// ============================================================================
module qupls_io_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 5,
    parameter int ADRW  = 32,
    parameter int DATW  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enq_v,
    output logic                          enq_rdy,
    input  logic [TAGW-1:0]               enq_tag,
    input  logic                          enq_store,
    input  logic [ADRW-1:0]               enq_adr,
    input  logic [DATW-1:0]               enq_data,
    input  logic [DATW/8-1:0]             enq_sel,
    input  logic                          rob_head_v,
    input  logic [TAGW-1:0]               rob_head_tag,
    input  logic                          flush,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADRW-1:0]               mem_adr,
    output logic [DATW-1:0]               mem_wdata,
    output logic [DATW/8-1:0]             mem_sel,
    input  logic                          mem_ack,
    input  logic [DATW-1:0]               mem_rdata,
    output logic                          done_v,
    output logic [TAGW-1:0]               done_tag,
    output logic [DATW-1:0]               done_data,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = DATW/8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;

    logic [TAGW-1:0] r_q_tag   [DEPTH];
    logic            r_q_store [DEPTH];
    logic [ADRW-1:0] r_q_adr   [DEPTH];
    logic [DATW-1:0] r_q_data  [DEPTH];
    logic [SW-1:0]   r_q_sel   [DEPTH];

    logic            w_push;
    logic            w_ack;
    logic            w_match;
    logic [CW-1:0]   w_next_cnt;

    assign enq_rdy    = (count < CW'(DEPTH));
    assign w_push     = enq_v & enq_rdy & ~flush;
    // An ack only counts against a live request; stray acks are dropped.
    assign w_ack      = mem_ack & mem_req & (r_state == ST_BUSY);
    assign w_match    = rob_head_v && (rob_head_tag == r_q_tag[r_rd_ptr]) && (count != '0);
    assign w_next_cnt = count + CW'(w_push) - CW'(w_ack);

    // Payload storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_tag[r_wr_ptr]   <= enq_tag;
            r_q_store[r_wr_ptr] <= enq_store;
            r_q_adr[r_wr_ptr]   <= enq_adr;
            r_q_data[r_wr_ptr]  <= enq_data;
            r_q_sel[r_wr_ptr]   <= enq_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            count     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            mem_sel   <= '0;
            done_v    <= 1'b0;
            done_tag  <= '0;
            done_data <= '0;
        end else begin
            done_v <= 1'b0;
            if (w_ack) begin
                done_v    <= 1'b1;
                done_tag  <= r_q_tag[r_rd_ptr];
                done_data <= r_q_store[r_rd_ptr] ? '0 : mem_rdata;
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                r_rd_ptr  <= r_rd_ptr + PW'(1);
            end
            if (flush) begin
                // The in-flight op is non-speculative, so it survives a flush.
                if (r_state == ST_BUSY) begin
                    r_wr_ptr <= r_rd_ptr + PW'(1);
                    count    <= w_ack ? CW'(0) : CW'(1);
                    r_state  <= w_ack ? ST_IDLE : ST_BUSY;
                end else begin
                    r_wr_ptr <= r_rd_ptr;
                    count    <= '0;
                    r_state  <= ST_IDLE;
                end
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                count <= w_next_cnt;
                case (r_state)
                    ST_IDLE: begin
                        if (w_push)
                            r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (w_match) begin
                            r_state   <= ST_BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= r_q_store[r_rd_ptr];
                            mem_adr   <= r_q_adr[r_rd_ptr];
                            mem_wdata <= r_q_data[r_rd_ptr];
                            mem_sel   <= r_q_sel[r_rd_ptr];
                        end
                    end
                    ST_BUSY: begin
                        if (w_ack)
                            r_state <= (w_next_cnt != '0) ? ST_WAIT : ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/qupls_io_sequencer.md
Name: qupls_io_sequencer

Overview:
- Downstream consumer of the decoder's I/O flag: a load or store whose cache attribute field is 0 is tagged as I/O and routed here instead of to the cached load/store path.
- Holds these ops in a small program-order FIFO.
- Issues exactly one to the uncached memory port at a time, and only when the entry is the oldest uncommitted instruction (non-speculative, strongly ordered).
- Reports completion back to the ROB by tag.

Parameters:
DEPTH, 4, number of queued I/O ops (power of 2, >=2)
TAGW, 5, ROB tag width
ADRW, 32, physical address width
DATW, 64, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enq_v  in  1  I/O op presented by decode/rename
enq_rdy  out  1  queue can accept (count < DEPTH)
enq_tag  in  TAGW  ROB tag of op
enq_store  in  1  1=store, 0=load
enq_adr  in  ADRW  address
enq_data  in  DATW  store data (ignored for loads)
enq_sel  in  DATW/8  byte lane selects
rob_head_v  in  1  rob_head_tag valid
rob_head_tag  in  TAGW  tag of oldest uncommitted instruction
flush  in  1  pipeline flush; discard un-issued entries
mem_req  out  1  uncached bus request
mem_we  out  1  write enable
mem_adr  out  ADRW  bus address
mem_wdata  out  DATW  bus write data
mem_sel  out  DATW/8  bus byte selects
mem_ack  in  1  transaction complete (valid only while mem_req=1)
mem_rdata  in  DATW  read data, valid with mem_ack
done_v  out  1  one-cycle completion pulse
done_tag  out  TAGW  tag of completed op
done_data  out  DATW  load data (0 for stores)
count  out  $clog2(DEPTH+1)  entries held, including the in-flight one

Behaviour:
- Reset values: state IDLE, count=0, rd/wr pointers=0, mem_req=0, mem_we=0, mem_adr=0, mem_wdata=0, mem_sel=0, done_v=0, done_tag=0, done_data=0. enq_rdy=1 after reset.
- enq_rdy is combinational (count<DEPTH). Enqueue occurs on a cycle with enq_v & enq_rdy & ~flush. The entry is written at the tail and is visible at the head the next cycle. Pointers wrap modulo DEPTH.
- State machine:
  - IDLE (queue empty): go to WAIT the cycle after count becomes nonzero.
  - WAIT (head held, not yet oldest): if rob_head_v && rob_head_tag==head.tag, go to BUSY. mem_req and the bus fields are registered from the head entry, so mem_req rises the next cycle.
  - BUSY: mem_req=1 and all mem_* outputs stable until mem_ack. On the mem_ack cycle:
    - the head is popped;
    - done_tag and done_data are registered (done_data = mem_rdata for loads, 0 for stores);
    - done_v=1 on the following cycle only;
    - mem_req drops the following cycle;
    - next state is WAIT if entries remain after the pop, else IDLE.
- Minimum timing:
  - enqueue at N, match at N+1, mem_req at N+2;
  - ack at M, done_v and mem_req=0 at M+1;
  - next request no earlier than M+2.
- Only one transaction outstanding at any time. No request is issued without a head-tag match.
- Simultaneous enqueue and pop: both happen; count unchanged.
- Full: enq_rdy=0, enq_v ignored, no overwrite. Empty: no pop, state IDLE.
- Flush:
  - In IDLE/WAIT: all entries discarded; count=0 and state IDLE next cycle.
  - In BUSY: the in-flight head is kept and completes normally, including its done_v pulse, because it is non-speculative. All other entries are discarded, so count=1 next cycle.
  - Flush with enq_v in the same cycle: flush wins and the enqueue is dropped.
  - Flush with mem_ack in the same cycle: head popped, others discarded, count=0, done_v still pulses.
- Reset mid-BUSY: mem_req=0 next cycle, queue cleared, no done_v. A late mem_ack is ignored.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Single load: enq tag=3, adr=0xFFDC0000; rob_head_tag=3 at N+1 -> mem_req=1, mem_we=0 at N+2; ack with rdata=0x1234 two cycles later -> done_v=1, done_tag=3, done_data=0x1234 for exactly one cycle; count returns to 0.
- Ordering stall: enq tags 5 (store), 6 (load); rob_head_tag=4 for 10 cycles -> mem_req stays 0. Then head=5 -> store issues with mem_we=1 and correct wdata/sel. Tag 6 does not issue until rob_head_tag=6 after done for tag 5.
- Full: enqueue 4 ops with no head match -> enq_rdy=0, count=4; 5th enq_v dropped. After one completes, enq_rdy=1 the cycle after the pop.
- Flush in WAIT with 3 entries -> count=0, state IDLE, no mem_req ever. Flush in BUSY with 3 entries -> in-flight op completes with done_v, count=0 afterwards, no further requests.
- Simultaneous flush+mem_ack, and enq_v+flush same cycle -> done_v pulses once, nothing enqueued, count=0.
- Reset asserted while mem_req=1 -> mem_req=0 next cycle, count=0, a subsequent mem_ack produces no done_v.
